price_table_writer: RTL

- Write side of the vending machine's 8-entry price table.
- Holds eight 6-bit price registers whose outputs drive the price-select mux inputs I7..I0 directly. Product n (0..7) is the mux's sel=n, which maps to price_I(7-n).
- Accepts single-entry updates and atomic 8-entry bulk loads over a valid/ready handshake.
- Stalls updates while a vend transaction is in progress.

---
 rtl/price_table_writer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/price_table_writer.sv
// Write side of the vending machine price table: eight live price registers
// updated by single writes or by atomic 8-entry bulk loads through a shadow bank.
module price_table_writer #(
   parameter int WIDTH = 6,
   parameter logic [WIDTH-1:0] DEFAULT_PRICE = WIDTH'(10)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic             wr_mode,
   input  logic [2:0]       wr_sel,
   input  logic [WIDTH-1:0] wr_price,
   input  logic             lock,
   output logic [WIDTH-1:0] price_I7,
   output logic [WIDTH-1:0] price_I6,
   output logic [WIDTH-1:0] price_I5,
   output logic [WIDTH-1:0] price_I4,
   output logic [WIDTH-1:0] price_I3,
   output logic [WIDTH-1:0] price_I2,
   output logic [WIDTH-1:0] price_I1,
   output logic [WIDTH-1:0] price_I0,
   output logic             bulk_busy,
   output logic             load_done,
   output logic             err_zero
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BULK   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] live   [8];
   logic [WIDTH-1:0] shadow [8];
   logic [2:0]       count;
   logic             accept;
   logic             price_zero;

   // Indexed by product number; the mux input for product n is I(7-n).
   assign price_I7 = live[0];
   assign price_I6 = live[1];
   assign price_I5 = live[2];
   assign price_I4 = live[3];
   assign price_I3 = live[4];
   assign price_I2 = live[5];
   assign price_I1 = live[6];
   assign price_I0 = live[7];

   assign wr_ready   = rst_n & ~lock & (state != COMMIT);
   assign accept     = wr_valid & wr_ready;
   assign price_zero = (wr_price == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      bulk_busy  = 1'b0;
      case (state)
         IDLE: begin
            if (accept && wr_mode) begin
               next_state = BULK;
            end
         end
         BULK: begin
            bulk_busy = 1'b1;
            if (accept && (count == 3'd7)) begin
               next_state = COMMIT;
            end
         end
         COMMIT: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Zero-price beats complete the handshake but leave their target entry untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            live[i]   <= DEFAULT_PRICE;
            shadow[i] <= DEFAULT_PRICE;
         end
         count     <= 3'd0;
         load_done <= 1'b0;
         err_zero  <= 1'b0;
      end else begin
         load_done <= 1'b0;
         err_zero  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  err_zero <= price_zero;
                  if (!wr_mode) begin
                     if (!price_zero) begin
                        live[wr_sel] <= wr_price;
                     end
                     load_done <= 1'b1;
                  end else begin
                     for (int i = 0; i < 8; i++) begin
                        shadow[i] <= live[i];
                     end
                     if (!price_zero) begin
                        shadow[0] <= wr_price;
                     end
                     count <= 3'd1;
                  end
               end
            end
            BULK: begin
               if (accept) begin
                  err_zero <= price_zero;
                  if (!price_zero) begin
                     shadow[count] <= wr_price;
                  end
                  count <= count + 3'd1;
               end
            end
            COMMIT: begin
               for (int i = 0; i < 8; i++) begin
                  live[i] <= shadow[i];
               end
               load_done <= 1'b1;
               count     <= 3'd0;
            end
            default: begin
               count <= 3'd0;
            end
         endcase
      end
   end

endmodule
